// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a two-register bus window feeds a byte FIFO,
// and a START/DATA/STOP shifter drives a registered serial line, LSB first.
module mmio_uart_tx #(
  parameter int          CLK_DIV    = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift;
  logic          tx_q, tx_nxt;
  logic          sel, push, push_ok, pop, stat_wr, shift_en;
  logic          full, empty, div_last, frame_active;
  logic          unused_bits;

  function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
    logic [31:0] cw;
    cw = 32'(c);
    return (cw > 32'd15) ? 4'hF : cw[3:0];
  endfunction

  assign unused_bits  = ^{mem_wdata[31:8], mem_addr[1:0]};
  assign sel          = (mem_addr[31:3] == BASE_ADDR[31:3]);
  assign push         = sel & mem_we & ~mem_addr[2];
  assign stat_wr      = sel & mem_we & mem_addr[2];
  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  // A push into a full FIFO is only accepted when the same edge frees a slot.
  assign push_ok      = push & (~full | pop);
  assign div_last     = (div_cnt == DW'(CLK_DIV - 1));
  assign frame_active = (state != IDLE);

  assign tx        = tx_q;
  assign tx_busy   = frame_active | ~empty;
  assign mem_rdata = (mem_re & sel & mem_addr[2]) ?
                     {24'h0, sat_count(count), overflow, frame_active, empty, full} : 32'h0;

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_idx;
    tx_nxt    = tx_q;
    pop       = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt  = 1'b1;
        div_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (div_last) begin
          div_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
          tx_nxt    = shift[0];
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      DATA: begin
        if (div_last) begin
          div_nxt  = '0;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_idx + 3'd1;
            tx_nxt  = shift[1];
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      STOP: begin
        if (div_last) begin
          div_nxt = '0;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_idx <= bit_nxt;
      tx_q    <= tx_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      if (stat_wr)
        overflow <= 1'b0;
      else if (push & ~push_ok)
        overflow <= 1'b1;
    end
  end

  // Byte storage and shifter carry data only, so they are left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= mem_wdata[7:0];
    if (pop)
      shift <= fifo_mem[rd_ptr];
    else if (shift_en)
      shift <= {1'b0, shift[7:1]};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and random bus traffic compared cycle by cycle
// against a queue-and-frame-timer model of the transmitter.
module tb_mmio_uart_tx;

  localparam int          DIV   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * DIV;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, tx, tx_busy;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes, byte on the wire, cycles of frame left.
  logic [7:0]  q[$];
  logic [7:0]  cur_byte = 8'h00;
  int          frame_left = 0;
  logic        ovf = 1'b0;
  logic [31:0] last_rdata;

  mmio_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [3:0] c;
    c = (q.size() > 15) ? 4'hF : 4'(q.size());
    return {24'h0, c, ovf, (frame_left > 0), (q.size() == 0), (q.size() == DEPTH)};
  endfunction

  function automatic logic exp_tx();
    int pos;
    if (frame_left == 0) return 1'b1;
    pos = (FRAME - frame_left) / DIV;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return cur_byte[pos-1];
    return 1'b1;
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    return a[31:3] == BASE[31:3];
  endfunction

  task automatic model_edge(input logic r, input logic we, input logic [31:0] a, input logic [7:0] d);
    if (r) begin
      q.delete();
      frame_left = 0;
      ovf = 1'b0;
      return;
    end
    if (frame_left > 0) frame_left--;
    if (frame_left == 0 && q.size() > 0) begin
      cur_byte = q.pop_front();
      frame_left = FRAME;
    end
    if (we && in_window(a) && !a[2]) begin
      if (q.size() < DEPTH) q.push_back(d);
      else ovf = 1'b1;
    end
    if (we && in_window(a) && a[2]) ovf = 1'b0;
  endtask

  // One bus cycle: drive after the falling edge, check rdata, clock, check line.
  task automatic cyc(input logic r, input logic we, input logic re,
                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    rst = r; mem_we = we; mem_re = re; mem_addr = a; mem_wdata = d;
    #1;
    exp_rd = (re && in_window(a) && a[2]) ? exp_status() : 32'h0;
    last_rdata = mem_rdata;
    check32("rdata", mem_rdata, exp_rd);
    @(posedge clk);
    model_edge(r, we, a, d[7:0]);
    @(negedge clk);
    rst = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    check32("tx", {31'h0, tx}, {31'h0, exp_tx()});
    check32("tx_busy", {31'h0, tx_busy}, {31'h0, (frame_left > 0) || (q.size() > 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 32'h0);
  endtask

  initial begin
    int n;
    int sel;
    rst = 1'b1; mem_we = 1'b0; mem_re = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check32("reset_tx", {31'h0, tx}, 32'h1);
    check32("reset_busy", {31'h0, tx_busy}, 32'h0);

    // Register window reads while idle.
    rd(BASE + 32'h4);
    check32("status_idle", last_rdata, 32'h0000_0002);
    rd(BASE);
    check32("txdata_read", last_rdata, 32'h0);
    rd(BASE + 32'h20);
    check32("outside_read", last_rdata, 32'h0);
    wr(BASE + 32'h20, 32'h77);
    rd(BASE + 32'h4);
    check32("outside_write_no_effect", last_rdata, 32'h0000_0002);

    // Single frame, then two back-to-back frames.
    wr(BASE, 32'h55);
    idle(FRAME + 4);
    wr(BASE, 32'hA5);
    wr(BASE, 32'h3C);
    idle(2 * FRAME + 4);
    wr(BASE, {24'h0, 8'($urandom)});
    idle(FRAME + 2);

    // Overrun: ten stores during one frame, the last is dropped.
    for (int i = 0; i < 10; i++) wr(BASE, $urandom);
    rd(BASE + 32'h4);
    check32("status_full_ovf", last_rdata, 32'h0000_008D);
    wr(BASE + 32'h4, 32'h0);
    rd(BASE + 32'h4);
    check32("status_ovf_cleared", last_rdata, 32'h0000_0085);
    idle(9 * FRAME + 4);

    // Push on the very edge that pops a full FIFO.
    wr(BASE, $urandom);
    for (int i = 0; i < DEPTH; i++) wr(BASE, $urandom);
    n = 0;
    while (frame_left != 1 && n < 100) begin
      idle(1);
      n++;
    end
    check32("pop_edge_reached", {31'h0, n < 100}, 32'h1);
    wr(BASE, 32'hE7);
    rd(BASE + 32'h4);
    check32("status_full_no_ovf", last_rdata, 32'h0000_0085);
    idle(9 * FRAME + 4);

    // Reset in the middle of an 0xFF frame with bytes queued.
    wr(BASE, 32'hFF);
    for (int i = 0; i < 3; i++) wr(BASE, $urandom);
    idle(12);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check32("rst_tx_high", {31'h0, tx}, 32'h1);
    rd(BASE + 32'h4);
    check32("rst_status", last_rdata, 32'h0000_0002);
    idle(2 * FRAME);

    // Random bus traffic.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    wr(BASE | 32'($urandom_range(0, 3)), $urandom);
        2:       rd(BASE + 32'h4 + 32'($urandom_range(0, 3)));
        3:       wr(BASE + 32'h4, $urandom);
        4:       rd(BASE);
        5:       wr(BASE + 32'h20, $urandom);
        6:       cyc(1'b0, 1'($urandom), 1'b1, $urandom, $urandom);
        default: idle(1);
      endcase
    end
    idle((DEPTH + 1) * FRAME + 4);
    rd(BASE + 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
